// File: rtl/mem_arb_pkg.sv
// Shared types and RV32 load/store encodings for the instruction/data memory arbiter.
// Also holds the alignment/legality check used when a data request is arbitrated.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // High when the data access is misaligned for its width or uses an unsupported funct3.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lo);
    logic err;
    err = 1'b1;
    if (we) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = lo[0];
        F3_SW:   err = (lo != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = lo[0];
        F3_LW:         err = (lo != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable and data replication, load lane
// extraction with sign/zero extension. Results for illegal encodings are gated by the caller.
module lsu_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_read,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wlane,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_mem_read >> {i_lo, 3'b000};

  always_comb begin
    o_byte_en = 4'b0000;
    o_wlane   = i_wdata;
    case (i_funct3)
      F3_SB: begin
        o_byte_en = 4'b0001 << i_lo;
        o_wlane   = {4{i_wdata[7:0]}};
      end
      F3_SH: begin
        o_byte_en = 4'b0011 << i_lo;
        o_wlane   = {2{i_wdata[15:0]}};
      end
      F3_SW:   o_byte_en = 4'b1111;
      default: o_byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_LB:   o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_rdata = w_shifted;
      F3_LBU:  o_rdata = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_rdata = {16'd0, w_shifted[15:0]};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one single-port memory, with a
// starvation limit on back-to-back data grants and RV32 byte/half/word lane handling.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] addr,
  output logic        rd_en,
  output logic        wr_en,
  output logic [3:0]  byte_en,
  output logic [31:0] mem_write,
  input  logic [31:0] mem_read
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sel_if;
  logic               r_err;
  logic               r_if_gnt;
  logic               r_d_gnt;
  logic               r_rd_en;
  logic               r_wr_en;
  logic               r_if_rvalid;
  logic               r_d_rvalid;
  logic               r_d_err;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;

  logic               w_arb;
  logic               w_accept;
  logic               w_starved;
  logic               w_pick_if;
  logic               w_d_err_in;
  logic [3:0]         w_be;
  logic [31:0]        w_wlane;
  logic [31:0]        w_rdata_ext;

  assign w_arb      = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_accept   = w_arb && (if_req || d_req);
  assign w_starved  = (r_cnt == CNT_W'(STARVE_LIMIT));
  assign w_pick_if  = if_req && (!d_req || w_starved);
  assign w_d_err_in = access_err(d_we, d_funct3, d_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel_if    <= 1'b0;
      r_err       <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          r_if_rvalid <= 1'b0;
          r_d_rvalid  <= 1'b0;
          r_d_err     <= 1'b0;
          if (w_accept) begin
            r_state  <= ST_ACCESS;
            r_sel_if <= w_pick_if;
            r_if_gnt <= w_pick_if;
            r_d_gnt  <= !w_pick_if;
            r_rd_en  <= w_pick_if || (!d_we && !w_d_err_in);
            r_wr_en  <= !w_pick_if && d_we && !w_d_err_in;
            r_err    <= !w_pick_if && w_d_err_in;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_if_gnt    <= 1'b0;
          r_d_gnt     <= 1'b0;
          r_rd_en     <= 1'b0;
          r_wr_en     <= 1'b0;
          r_if_rvalid <= r_sel_if;
          r_d_rvalid  <= !r_sel_if;
          r_d_err     <= r_err;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Counts data grants that bypassed a waiting fetch; saturation is implied
      // because a saturated counter forces the fetch grant, which clears it.
      if (!if_req || (w_accept && w_pick_if)) begin
        r_cnt <= '0;
      end else if (w_accept && !w_starved) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr   <= w_pick_if ? if_addr : d_addr;
      r_we     <= d_we;
      r_funct3 <= d_funct3;
      r_wdata  <= d_wdata;
    end
  end

  lsu_align u_lsu_align (
    .i_funct3   (r_funct3),
    .i_lo       (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_mem_read (mem_read),
    .o_byte_en  (w_be),
    .o_wlane    (w_wlane),
    .o_rdata    (w_rdata_ext)
  );

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign rd_en     = r_rd_en;
  assign wr_en     = r_wr_en;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign d_err     = r_d_err;
  assign addr      = (r_state == ST_ACCESS) ? {r_addr[31:2], 2'b00} : '0;
  assign byte_en   = r_wr_en ? w_be : 4'b0000;
  assign mem_write = r_wr_en ? w_wlane : '0;
  assign if_rdata  = r_if_rvalid ? mem_read : '0;
  assign d_rdata   = (r_d_rvalid && !r_d_err && !r_we) ? w_rdata_ext : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, loads, stores, error cases, starvation order and resets.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] addr;
  logic        rd_en, wr_en;
  logic [3:0]  byte_en;
  logic [31:0] mem_write, mem_read;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .byte_en(byte_en),
    .mem_write(mem_write), .mem_read(mem_read)
  );

  always #5 clk = ~clk;

  function automatic logic [138:0] all_outs();
    return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
            addr, rd_en, wr_en, byte_en, mem_write};
  endfunction

  // Drives one data transaction and samples the ACCESS and RESP cycles.
  task automatic run_data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] mr,
                          output logic [6:0] acc, output logic [31:0] acc_addr,
                          output logic [31:0] acc_mw, output logic [2:0] rsp,
                          output logic [31:0] rsp_data);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    @(negedge clk);
    acc      = {d_gnt, rd_en, wr_en, byte_en};
    acc_addr = addr;
    acc_mw   = mem_write;
    d_req    = 1'b0;
    mem_read = mr;
    @(negedge clk);
    rsp      = {d_rvalid, d_err, if_rvalid};
    rsp_data = d_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (all_outs() !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, all_outs());
      end
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_fetch();
    logic [6:0]  acc;
    logic [31:0] acc_addr;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0103;
    @(negedge clk);
    acc = {if_gnt, d_gnt, rd_en, wr_en, byte_en[2:0]};
    acc_addr = addr;
    if_req = 1'b0; mem_read = 32'h0010_0093;
    n_checks++;
    if (acc !== 7'b1010000 || acc_addr !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL fetch_access: got ctl=%b addr=%h want ctl=1010000 addr=00000100", acc, acc_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h0010_0093}) begin
      n_fail++;
      $display("FAIL fetch_resp: got rv=%b drv=%b data=%h want 1 0 00100093",
               if_rvalid, d_rvalid, if_rdata);
    end
  endtask

  task automatic test_load();
    logic [6:0]  acc;
    logic [31:0] aa, mw, rd;
    logic [2:0]  rsp;
    logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adrs [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h3000};
    logic [31:0] mrs  [5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                              32'hDEAD_BEEF};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                              32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      run_data(1'b0, f3s[i], adrs[i], 32'h0, mrs[i], acc, aa, mw, rsp, rd);
      n_checks++;
      if (acc !== 7'b1100000 || aa !== {adrs[i][31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL load_access[%0d]: got ctl=%b addr=%h want 1100000 addr=%h",
                 i, acc, aa, {adrs[i][31:2], 2'b00});
      end
      n_checks++;
      if (rsp !== 3'b100 || rd !== exps[i]) begin
        n_fail++;
        $display("FAIL load_resp[%0d]: got rv/err/ifrv=%b data=%h want 100 data=%h",
                 i, rsp, rd, exps[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [6:0]  acc;
    logic [31:0] aa, mw, rd;
    logic [2:0]  rsp;
    logic [2:0]  f3s  [3] = '{3'd1, 3'd0, 3'd2};
    logic [31:0] adrs [3] = '{32'h2002, 32'h5001, 32'h6000};
    logic [31:0] wds  [3] = '{32'h1234_ABCD, 32'h0000_00EF, 32'hCAFE_F00D};
    logic [3:0]  bes  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] mws  [3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      run_data(1'b1, f3s[i], adrs[i], wds[i], 32'h5555_5555, acc, aa, mw, rsp, rd);
      n_checks++;
      if (acc !== {3'b101, bes[i]} || aa !== {adrs[i][31:2], 2'b00} || mw !== mws[i]) begin
        n_fail++;
        $display("FAIL store_access[%0d]: got ctl=%b addr=%h wr=%h want ctl=101%b addr=%h wr=%h",
                 i, acc, aa, mw, bes[i], {adrs[i][31:2], 2'b00}, mws[i]);
      end
      n_checks++;
      if (rsp !== 3'b100 || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL store_resp[%0d]: got rv/err/ifrv=%b data=%h want 100 data=0", i, rsp, rd);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [6:0]  acc;
    logic [31:0] aa, mw, rd;
    logic [2:0]  rsp;
    logic        wes  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s  [4] = '{3'd2, 3'd1, 3'd3, 3'd6};
    logic [31:0] adrs [4] = '{32'h3001, 32'h2001, 32'h7000, 32'h7004};
    for (int i = 0; i < 4; i++) begin
      run_data(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 32'hA5A5_A5A5, acc, aa, mw, rsp, rd);
      n_checks++;
      if (acc !== 7'b1000000 || mw !== 32'h0) begin
        n_fail++;
        $display("FAIL err_access[%0d]: got ctl=%b wr=%h want ctl=1000000 wr=0", i, acc, mw);
      end
      n_checks++;
      if (rsp !== 3'b110 || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL err_resp[%0d]: got rv/err/ifrv=%b data=%h want 110 data=0", i, rsp, rd);
      end
    end
  endtask

  task automatic test_starve();
    logic [9:0] seq;
    int         n;
    int         last;
    seq = '0; n = 0; last = -1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h9000;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h8000;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        seq[n] = if_gnt;
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== 2) begin
            n_fail++;
            $display("FAIL grant_spacing[%0d]: got %0d cycles want 2", n, cyc - last);
          end
        end
        last = cyc;
        n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL starve_timeout: got %0d grants want 10", n);
    end
    n_checks++;
    if (seq !== 10'b10000_10000) begin
      n_fail++;
      $display("FAIL starve_order: got %b want 1000010000 (bit0 first, 1=fetch)", seq);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h4000;
    @(negedge clk);
    n_checks++;
    if ({d_gnt, rd_en} !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_access: got gnt/rd=%b want 11", {d_gnt, rd_en});
    end
    rst = 1'b1; d_req = 1'b0; mem_read = 32'h1122_3344;
    @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h want 0", all_outs());
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({d_rvalid, d_rdata, rd_en} !== '0) begin
        n_fail++;
        $display("FAIL midreset_no_rvalid[%0d]: got rv=%b data=%h rd=%b want 0",
                 i, d_rvalid, d_rdata, rd_en);
      end
    end
    // A fresh fetch must be granted on the very next edge, proving the arbiter is idle.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    @(negedge clk);
    n_checks++;
    if ({if_gnt, rd_en, addr} !== {2'b11, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL midreset_idle: got gnt/rd=%b addr=%h want 11 addr=00000200",
               {if_gnt, rd_en}, addr);
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_funct3 = '0; d_addr = '0; d_wdata = '0; mem_read = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_starve();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
